// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl -- instruction fetch controller with a small instruction buffer.
//
// Issues one instruction-memory request at a time from the current PC. Each
// response is queued in a FIFO that decode drains. A buffer slot is reserved
// before a request issues, so a response always has room.
// A taken branch redirects the PC and flushes the buffer. If the branch
// arrives while a request is in flight, the late response is discarded.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   en                       fetch enable (gates new requests only)
//   q_PC / d_PC, pc_en       PC register output / next-PC and write enable
//   imem_req, imem_addr      memory request and address
//   imem_gnt                 request accepted (qualified by imem_req)
//   imem_rvalid, imem_rdata  read response
//   br_taken, br_target      redirect strobe and target
//   instr_valid, instr,      buffer head presented to decode
//   instr_pc
//   dec_ready                decode accepts the head entry
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int BUF_DEPTH = 2            // 2 or 4 entries
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] q_PC,
  output logic [31:0] d_PC,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        dec_ready
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_t          state, state_n;
  logic            drop, drop_n;
  logic [CW-1:0]   count, count_n;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic            valid_q;
  logic            push, pop, flush, can_issue;
  entry_t          buf_mem [BUF_DEPTH];

  // The two low target bits are always forced to zero.
  logic unused_br_lsb;
  assign unused_br_lsb = ^br_target[1:0];

  // Occupancy bookkeeping. A redirect flushes and takes priority over the
  // coincident push/pop.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    pop     = 1'b0;
    push    = 1'b0;
    flush   = 1'b0;
    count_n = count;
    if (!rst) begin
      flush = br_taken;
      pop   = valid_q && dec_ready && !br_taken;
      push  = (state == S_WAIT) && imem_rvalid && !drop && !br_taken;
      if (flush) begin
        count_n = '0;
      end else begin
        case ({push, pop})
          2'b10:   count_n = count + CW'(1);
          2'b01:   count_n = count - CW'(1);
          default: count_n = count;
        endcase
      end
    end
  end

  // A new request may start only if the slot for its response is free. The
  // check uses the occupancy after this cycle's push/pop/flush. A pop
  // therefore frees a slot in time to request on the very next cycle.
  assign can_issue = en && (count_n < DEPTH_C);

  // Next state and the combinational request/PC outputs.
  always_comb begin
    state_n   = state;
    drop_n    = drop;
    imem_req  = 1'b0;
    imem_addr = q_PC;
    pc_en     = 1'b0;
    d_PC      = q_PC;
    if (!rst) begin
      if (br_taken) begin
        pc_en = 1'b1;
        d_PC  = {br_target[31:2], 2'b00};
      end
      unique case (state)
        S_IDLE: begin
          if (can_issue) state_n = S_REQ;
        end
        S_REQ: begin
          // A redirect withdraws the request. The FSM stays here, so the
          // next request uses the redirected PC.
          imem_req = !br_taken;
          if (!br_taken && imem_gnt) begin
            pc_en   = 1'b1;
            d_PC    = q_PC + 32'd4;
            state_n = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            drop_n  = 1'b0;
            state_n = can_issue ? S_REQ : S_IDLE;
          end else if (br_taken) begin
            drop_n = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. All flops then
    // update together from the values they had before the clock edge.
    if (rst) begin
      state   <= S_IDLE;
      drop    <= 1'b0;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      drop    <= drop_n;
      count   <= count_n;
      valid_q <= (count_n != '0);
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // NOTE: the buffer storage has no reset. count and valid_q decide which
  // entries are live, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (push) begin
      // The PC has already advanced past this fetch, so its address is q_PC-4.
      buf_mem[wr_ptr] <= '{pc: q_PC - 32'd4, word: imem_rdata};
    end
  end

  assign instr_valid = valid_q && !rst;
  assign instr       = buf_mem[rd_ptr].word;
  assign instr_pc    = buf_mem[rd_ptr].pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl -- self-checking bench for fetch_ctrl (BUF_DEPTH = 2).
// The bench plays the PC register and the instruction memory. A behavioural
// model (a queue of fetched entries plus pending/in-flight flags) predicts
// every output on every cycle. Directed scenarios come first, then random
// traffic.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst, en;
  logic [31:0] q_PC, d_PC;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
  logic        dec_ready;

  fetch_ctrl #(.BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .q_PC(q_PC), .d_PC(d_PC), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .br_taken(br_taken), .br_target(br_target),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .dec_ready(dec_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        mq[$];       // entries decode should see, oldest first
  bit          m_issue = 0; // a fetch is wanted and not yet granted
  bit          m_out   = 0; // a granted fetch awaits its response
  bit          m_drop  = 0; // that response belongs to a squashed path
  logic [31:0] m_addr  = '0;

  // DUT outputs sampled on the falling edge of the last cycle
  logic        s_req, s_pc_en, s_valid, s_grant;
  logic [31:0] s_addr, s_d_pc, s_instr, s_ipc;

  // One clock cycle. The caller has set the inputs beforehand.
  task automatic tick();
    logic        e_req, e_pc_en, e_valid, pop, resp, push;
    logic [31:0] e_dpc;
    @(negedge clk);
    s_req   = imem_req;   s_addr  = imem_addr;
    s_pc_en = pc_en;      s_d_pc  = d_PC;
    s_valid = instr_valid; s_instr = instr; s_ipc = instr_pc;
    s_grant = imem_req && imem_gnt;

    if (rst) begin
      e_req = 0; e_pc_en = 0; e_dpc = q_PC; e_valid = 0;
    end else begin
      e_valid = (mq.size() != 0);
      e_req   = m_issue && !br_taken;
      if (br_taken) begin
        e_pc_en = 1; e_dpc = {br_target[31:2], 2'b00};
      end else if (m_issue && imem_gnt) begin
        e_pc_en = 1; e_dpc = q_PC + 32'd4;
      end else begin
        e_pc_en = 0; e_dpc = q_PC;
      end
    end

    check("imem_req", s_req, e_req);
    check("pc_en", s_pc_en, e_pc_en);
    check("d_PC", s_d_pc, e_dpc);
    check("instr_valid", s_valid, e_valid);
    if (e_req) check("imem_addr", s_addr, q_PC);
    if (e_valid) begin
      check("instr", s_instr, mq[0].word);
      check("instr_pc", s_ipc, mq[0].pc);
    end

    if (rst) begin
      mq.delete(); m_issue = 0; m_out = 0; m_drop = 0;
    end else begin
      pop  = e_valid && dec_ready && !br_taken;
      resp = m_out && imem_rvalid;
      push = resp && !m_drop && !br_taken;
      if (br_taken) mq.delete();
      else if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{pc: m_addr, word: imem_rdata});
      if (m_issue) begin
        if (!br_taken && imem_gnt) begin
          m_issue = 0; m_out = 1; m_addr = q_PC;
        end
      end else if (m_out) begin
        if (resp) begin
          m_out = 0; m_drop = 0; m_issue = en && (mq.size() < DEPTH);
        end else if (br_taken) begin
          m_drop = 1;
        end
      end else begin
        m_issue = en && (mq.size() < DEPTH);
      end
    end

    @(posedge clk); #1;
    if (s_pc_en) q_PC = s_d_pc;   // the bench's PC register
  endtask

  task automatic idle_inputs();
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; br_taken = 0; br_target = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int resp_wait;

  initial begin
    rst = 1; en = 0; q_PC = '0; dec_ready = 0;
    idle_inputs();

    // Reset for five cycles.
    repeat (5) tick();
    check("rst_req", s_req, 0);
    check("rst_pc_en", s_pc_en, 0);
    check("rst_valid", s_valid, 0);
    check("rst_dpc", s_d_pc, 32'h0);

    // First fetch from 0x0.
    rst = 0; en = 1; dec_ready = 1;
    tick();                                      // IDLE -> REQ
    imem_gnt = 1; tick();                        // REQ, granted
    check("first_req", s_req, 1);
    check("first_addr", s_addr, 32'h0);
    check("first_pc_en", s_pc_en, 1);
    check("first_dpc", s_d_pc, 32'h4);
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hDEADBEEF; tick();
    imem_rvalid = 0; tick();                     // head popped here
    check("first_valid", s_valid, 1);
    check("first_instr", s_instr, 32'hDEADBEEF);
    check("first_ipc", s_ipc, 32'h0);

    // Fill the buffer with decode stalled.
    dec_ready = 0;
    imem_gnt = 1; tick();                        // fetch 0x4
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h1111_1111; tick();
    imem_rvalid = 0; imem_gnt = 1; tick();       // fetch 0x8
    check("fill_addr", s_addr, 32'h8);
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h2222_2222; tick();
    imem_rvalid = 0;
    check("pin_model_full", mq.size(), 2);
    tick();
    check("full_req_a", s_req, 0);
    check("full_head", s_ipc, 32'h4);
    tick();
    check("full_req_b", s_req, 0);
    dec_ready = 1; tick();                       // one pop
    check("pop_cycle_req", s_req, 0);
    dec_ready = 0; tick();
    check("after_pop_req", s_req, 1);
    check("after_pop_addr", s_addr, 32'hC);
    check("after_pop_instr", s_instr, 32'h2222_2222);

    // Redirect while a request is in flight.
    imem_gnt = 1; tick();                        // fetch 0xC, now WAIT
    imem_gnt = 0; br_taken = 1; br_target = 32'h103; tick();
    check("br_pc_en", s_pc_en, 1);
    check("br_dpc", s_d_pc, 32'h100);
    check("br_req", s_req, 0);
    br_taken = 0; imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0; tick();
    check("br_flushed", s_valid, 0);
    imem_rvalid = 0;
    check("pin_model_drop", mq.size(), 0);
    // Redirect inside REQ to reach the top of the address space.
    br_taken = 1; br_target = 32'hFFFF_FFFF; tick();
    check("redirect_req_addr", s_req, 0);
    check("dropped_valid", s_valid, 0);
    br_taken = 0; imem_gnt = 1; tick();
    check("wrap_addr", s_addr, 32'hFFFF_FFFC);
    check("wrap_dpc", s_d_pc, 32'h0);

    // Reset in WAIT, then a stale response just after release.
    imem_gnt = 0; rst = 1; tick();
    rst = 0; en = 0; imem_rvalid = 1; imem_rdata = 32'h5555_5555; tick();
    check("post_rst_req", s_req, 0);
    imem_rvalid = 0; tick();
    check("post_rst_valid", s_valid, 0);
    check("post_rst_idle", s_req, 0);

    // Random traffic against the model.
    resp_wait = 0;
    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      en          = ($urandom_range(0, 9) != 0);
      dec_ready   = ($urandom_range(0, 9) < 6);
      imem_gnt    = $urandom_range(0, 1);
      br_taken    = ($urandom_range(0, 11) == 0);
      br_target   = $urandom;
      imem_rvalid = (resp_wait == 1);
      imem_rdata  = $urandom;
      tick();
      if (resp_wait > 0) resp_wait--;
      if (s_grant) resp_wait = $urandom_range(1, 3);
      if (rst) resp_wait = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
